// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer path: screen defaults, fill modes,
// colour constants and the fill engine's state encoding.
package vga_pkg;

  localparam int H_RES_DEFAULT    = 160;
  localparam int V_RES_DEFAULT    = 120;
  localparam int COLOUR_W_DEFAULT = 3;

  localparam logic [1:0] MODE_IMAGE  = 2'b00;
  localparam logic [1:0] MODE_SOLID  = 2'b01;
  localparam logic [1:0] MODE_BORDER = 2'b10;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_t;

endpackage

// File: rtl/raster_scan_counter.sv
// Raster-order column/row/linear-address counter. The linear address is kept as
// its own counter so no multiplier is needed; it holds on the final pixel.
module raster_scan_counter
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES),
  localparam int AW = $clog2(H_RES * V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  assign last = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (clear) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (advance && !last) begin
      addr <= addr + AW'(1);
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= cy + YW'(1);
      end else begin
        cx <= cx + XW'(1);
      end
    end
  end

endmodule

// File: rtl/screen_fill_engine.sv
// Full-screen fill engine: sweeps every pixel once in raster order and emits one
// plot per clock, with colour from the image ROM, a solid colour or a border frame.
module screen_fill_engine
  import vga_pkg::*;
#(
  parameter int H_RES    = H_RES_DEFAULT,
  parameter int V_RES    = V_RES_DEFAULT,
  parameter int COLOUR_W = COLOUR_W_DEFAULT,
  parameter int ROM_LAT  = 1,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES),
  localparam int AW = $clog2(H_RES * V_RES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] fill_colour,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [AW-1:0]       rom_addr,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output fill_state_t         fsm_state
);

  localparam int DW = $clog2(ROM_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_RES - 1);

  fill_state_t state, state_next;
  logic [DW-1:0] drain_cnt;
  logic done_q, done_next;
  logic [1:0] mode_q;
  logic [COLOUR_W-1:0] fill_q;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [AW-1:0] addr;
  logic last, clear, advance;

  // Handshake: start is sampled only in IDLE; busy covers acceptance through the
  // last plot; done is a single-cycle pulse the cycle after, with busy low.
  assign clear   = (state == ST_IDLE) && start;
  assign advance = (state == ST_SWEEP);

  raster_scan_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .cx      (cx),
    .cy      (cy),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      done_q    <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SWEEP;
      ST_SWEEP: if (last) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Reserved mode 11 is folded into SOLID when latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_SOLID;
      fill_q <= '0;
    end else if (clear) begin
      mode_q <= (mode == MODE_IMAGE || mode == MODE_BORDER) ? mode : MODE_SOLID;
      fill_q <= fill_colour;
    end
  end

  logic                s0_valid, s0_img, s0_border;
  logic [COLOUR_W-1:0] s0_col;

  always_comb begin
    s0_valid  = (state == ST_SWEEP);
    s0_border = (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);
    s0_img    = s0_valid && (mode_q == MODE_IMAGE);
    s0_col    = '0;
    if (s0_valid && !s0_img && (mode_q != MODE_BORDER || s0_border))
      s0_col = fill_q;
  end

  // Pixel attributes travel alongside the ROM read so x, y and colour line up.
  logic                sr_v   [ROM_LAT];
  logic                sr_img [ROM_LAT];
  logic [XW-1:0]       sr_x   [ROM_LAT];
  logic [YW-1:0]       sr_y   [ROM_LAT];
  logic [COLOUR_W-1:0] sr_c   [ROM_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        sr_v[i]   <= 1'b0;
        sr_img[i] <= 1'b0;
        sr_x[i]   <= '0;
        sr_y[i]   <= '0;
        sr_c[i]   <= '0;
      end
    end else begin
      sr_v[0]   <= s0_valid;
      sr_img[0] <= s0_img;
      sr_x[0]   <= s0_valid ? cx : '0;
      sr_y[0]   <= s0_valid ? cy : '0;
      sr_c[0]   <= s0_col;
      for (int i = 1; i < ROM_LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_img[i] <= sr_img[i-1];
        sr_x[i]   <= sr_x[i-1];
        sr_y[i]   <= sr_y[i-1];
        sr_c[i]   <= sr_c[i-1];
      end
    end
  end

  assign plot      = sr_v[ROM_LAT-1];
  assign x         = sr_x[ROM_LAT-1];
  assign y         = sr_y[ROM_LAT-1];
  assign colour    = sr_img[ROM_LAT-1] ? rom_q : sr_c[ROM_LAT-1];
  assign rom_addr  = addr;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_screen_fill_engine.sv
// Directed bench for screen_fill_engine at 160x120 with ROM latencies 1 and 3.
module tb_screen_fill_engine;
  import vga_pkg::*;

  localparam int H    = 160;
  localparam int V    = 120;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [1:0]  mode   = 2'b00;
  logic [2:0]  fill   = 3'b000;

  logic [2:0]  rom_q1, colour1, rom_q3, colour3;
  logic [14:0] rom_addr1, rom_addr3;
  logic [7:0]  x1, x3;
  logic [6:0]  y1, y3;
  logic        plot1, busy1, done1, plot3, busy3, done3;
  fill_state_t st1, st3;

  screen_fill_engine #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .fill_colour(fill),
    .rom_q(rom_q1), .rom_addr(rom_addr1), .x(x1), .y(y1), .colour(colour1),
    .plot(plot1), .busy(busy1), .done(done1), .fsm_state(st1)
  );

  screen_fill_engine #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .fill_colour(fill),
    .rom_q(rom_q3), .rom_addr(rom_addr3), .x(x3), .y(y3), .colour(colour3),
    .plot(plot3), .busy(busy3), .done(done3), .fsm_state(st3)
  );

  // Image ROM models: contents are addr[2:0].
  logic [2:0] rom3_d [3];
  always @(posedge clk) begin
    rom_q1    <= rom_addr1[2:0];
    rom3_d[0] <= rom_addr3[2:0];
    rom3_d[1] <= rom3_d[0];
    rom3_d[2] <= rom3_d[1];
  end
  assign rom_q3 = rom3_d[2];

  int n_checks = 0;
  int n_pass   = 0;

  int n_plot, first_k, last_k, done_k, n_done, pos_err, col_err, busy_err, ovl_err;
  logic [7:0] first_x, last_x, wrap_x;
  logic [6:0] first_y, last_y, wrap_y;
  logic [1:0] exp_mode;
  logic [2:0] exp_fill;
  logic [2:0] pix_col [NPIX];

  // Starts a sweep on the latency-1 instance and observes it; must be entered at a negedge.
  task automatic run_sweep(input int budget, input int stop_at, input bit disturb);
    int  k, ex, ey;
    bit  fin, prev_edge, wrap_seen;
    logic [2:0] ec;
    n_plot = 0; first_k = -1; last_k = -1; done_k = -1; n_done = 0;
    pos_err = 0; col_err = 0; busy_err = 0; ovl_err = 0;
    ex = 0; ey = 0; k = 0; fin = 0; prev_edge = 0; wrap_seen = 0;
    wrap_x = '0; wrap_y = '0;
    start1 = 1'b1;
    while (!fin && k < budget) begin
      @(negedge clk);
      k++;
      if (k == 1) start1 = 1'b0;
      if (disturb && k == 100) begin
        mode = MODE_BORDER; fill = 3'b001; start1 = 1'b1;
      end
      if (disturb && k == 101) start1 = 1'b0;
      if (busy1 !== (k <= NPIX + 1)) busy_err++;
      if (plot1) begin
        if (first_k < 0) begin first_k = k; first_x = x1; first_y = y1; end
        if (prev_edge && !wrap_seen) begin wrap_x = x1; wrap_y = y1; wrap_seen = 1; end
        prev_edge = (x1 == 8'd159) && (y1 == 7'd0);
        last_k = k; last_x = x1; last_y = y1;
        if (x1 !== 8'(ex) || y1 !== 7'(ey)) pos_err++;
        case (exp_mode)
          MODE_IMAGE:  ec = 3'((int'(y1) * H + int'(x1)) % 8);
          MODE_BORDER: ec = (x1 == 0 || x1 == 8'd159 || y1 == 0 || y1 == 7'd119) ? exp_fill : 3'b000;
          default:     ec = exp_fill;
        endcase
        if (colour1 !== ec) col_err++;
        if (ey < V) pix_col[ey * H + ex] = colour1;
        if (done1) ovl_err++;
        n_plot++;
        ex++;
        if (ex == H) begin ex = 0; ey++; end
        if (n_plot == stop_at) fin = 1;
      end
      if (done1) begin n_done++; done_k = k; fin = 1; end
    end
  endtask

  task automatic test_reset();
    int quiet;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({plot1, busy1, done1} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {plot1, busy1, done1});
    else n_pass++;
    n_checks++;
    if ({x1, y1, colour1, rom_addr1} !== '0) $display("FAIL reset_data: got x=%0d y=%0d c=%0d a=%0d expected 0", x1, y1, colour1, rom_addr1);
    else n_pass++;
    n_checks++;
    if (st1 !== ST_IDLE || st3 !== ST_IDLE) $display("FAIL reset_state: got %0d/%0d expected %0d", st1, st3, ST_IDLE);
    else n_pass++;
    rst = 1'b1;
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if ({plot1, busy1, done1, x1, y1, colour1, rom_addr1} !== '0) quiet++;
      if ({plot3, busy3, done3, x3, y3, colour3, rom_addr3} !== '0) quiet++;
    end
    n_checks++;
    if (quiet !== 0) $display("FAIL idle_quiet: got %0d active cycles expected 0", quiet);
    else n_pass++;
  endtask

  task automatic test_image();
    int k3, n3, c3_err, p3_err, first3, done3_k, ex3, ey3;
    bit fin3;
    @(negedge clk);
    mode = MODE_IMAGE; fill = 3'b111; exp_mode = MODE_IMAGE; exp_fill = 3'b111;
    k3 = 0; n3 = 0; c3_err = 0; p3_err = 0; first3 = -1; done3_k = -1; ex3 = 0; ey3 = 0; fin3 = 0;
    fork
      run_sweep(NPIX + 50, 0, 0);
      begin
        start3 = 1'b1;
        while (!fin3 && k3 < NPIX + 50) begin
          @(negedge clk);
          k3++;
          if (k3 == 1) start3 = 1'b0;
          if (plot3) begin
            if (first3 < 0) first3 = k3;
            if (x3 !== 8'(ex3) || y3 !== 7'(ey3)) p3_err++;
            if (colour3 !== 3'((int'(y3) * H + int'(x3)) % 8)) c3_err++;
            n3++;
            ex3++;
            if (ex3 == H) begin ex3 = 0; ey3++; end
          end
          if (done3) begin done3_k = k3; fin3 = 1; end
        end
      end
    join
    n_checks++;
    if (n_plot !== NPIX) $display("FAIL image1_count: got %0d expected %0d", n_plot, NPIX);
    else n_pass++;
    n_checks++;
    if (col_err !== 0) $display("FAIL image1_colour: got %0d bad pixels expected 0", col_err);
    else n_pass++;
    n_checks++;
    if (n3 !== NPIX) $display("FAIL image3_count: got %0d expected %0d", n3, NPIX);
    else n_pass++;
    n_checks++;
    if (c3_err !== 0 || p3_err !== 0) $display("FAIL image3_pixels: got %0d colour / %0d position errors expected 0", c3_err, p3_err);
    else n_pass++;
    n_checks++;
    if (first3 !== 4) $display("FAIL image3_first_cycle: got t+%0d expected t+4", first3);
    else n_pass++;
    n_checks++;
    if (done3_k !== NPIX + 4) $display("FAIL image3_done_cycle: got t+%0d expected t+%0d", done3_k, NPIX + 4);
    else n_pass++;
  endtask

  task automatic test_solid_disturbed();
    @(negedge clk);
    mode = MODE_SOLID; fill = 3'b100; exp_mode = MODE_SOLID; exp_fill = 3'b100;
    run_sweep(NPIX + 50, 0, 1);
    n_checks++;
    if (n_plot !== NPIX) $display("FAIL solid_count: got %0d expected %0d", n_plot, NPIX);
    else n_pass++;
    n_checks++;
    if (first_k !== 2 || first_x !== 8'd0 || first_y !== 7'd0)
      $display("FAIL solid_first: got t+%0d (%0d,%0d) expected t+2 (0,0)", first_k, first_x, first_y);
    else n_pass++;
    n_checks++;
    if (wrap_x !== 8'd0 || wrap_y !== 7'd1) $display("FAIL solid_wrap: got (%0d,%0d) expected (0,1)", wrap_x, wrap_y);
    else n_pass++;
    n_checks++;
    if (last_x !== 8'd159 || last_y !== 7'd119 || last_k !== NPIX + 1)
      $display("FAIL solid_last: got t+%0d (%0d,%0d) expected t+%0d (159,119)", last_k, last_x, last_y, NPIX + 1);
    else n_pass++;
    n_checks++;
    if (done_k !== NPIX + 2 || n_done !== 1) $display("FAIL solid_done: got t+%0d x%0d expected t+%0d x1", done_k, n_done, NPIX + 2);
    else n_pass++;
    n_checks++;
    if (pos_err !== 0 || col_err !== 0) $display("FAIL solid_pixels: got %0d position / %0d colour errors expected 0", pos_err, col_err);
    else n_pass++;
    n_checks++;
    if (busy_err !== 0 || ovl_err !== 0) $display("FAIL solid_busy_done: got %0d busy / %0d overlap errors expected 0", busy_err, ovl_err);
    else n_pass++;
    n_checks++;
    if (rom_addr1 !== 15'd19199) $display("FAIL solid_addr_hold: got %0d expected 19199", rom_addr1);
    else n_pass++;
  endtask

  // Entered in the done cycle of the previous sweep.
  task automatic test_back_to_back();
    mode = MODE_BORDER; fill = 3'b010; exp_mode = MODE_BORDER; exp_fill = 3'b010;
    run_sweep(NPIX + 50, 0, 0);
    n_checks++;
    if (first_k !== 2 || n_plot !== NPIX) $display("FAIL b2b_start: got t+%0d with %0d plots expected t+2 with %0d", first_k, n_plot, NPIX);
    else n_pass++;
    n_checks++;
    if (col_err !== 0) $display("FAIL border_colour: got %0d bad pixels expected 0", col_err);
    else n_pass++;
    n_checks++;
    if (pix_col[5 * H + 0] !== 3'b010 || pix_col[7 * H + 159] !== 3'b010)
      $display("FAIL border_sides: got %b %b expected 010 010", pix_col[5 * H + 0], pix_col[7 * H + 159]);
    else n_pass++;
    n_checks++;
    if (pix_col[20] !== 3'b010 || pix_col[119 * H + 20] !== 3'b010)
      $display("FAIL border_top_bottom: got %b %b expected 010 010", pix_col[20], pix_col[119 * H + 20]);
    else n_pass++;
    n_checks++;
    if (pix_col[1 * H + 1] !== 3'b000 || pix_col[60 * H + 80] !== 3'b000)
      $display("FAIL border_interior: got %b %b expected 000 000", pix_col[1 * H + 1], pix_col[60 * H + 80]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    mode = MODE_SOLID; fill = 3'b100; exp_mode = MODE_SOLID; exp_fill = 3'b100;
    run_sweep(NPIX + 50, 5000, 0);
    n_checks++;
    if (n_plot !== 5000) $display("FAIL rstmid_reach: got %0d plots expected 5000", n_plot);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({plot1, busy1, done1} !== 3'b000) $display("FAIL rstmid_strobes: got %b expected 000", {plot1, busy1, done1});
    else n_pass++;
    n_checks++;
    if ({x1, y1, colour1, rom_addr1} !== '0) $display("FAIL rstmid_data: got x=%0d y=%0d c=%0d a=%0d expected 0", x1, y1, colour1, rom_addr1);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (plot1 || done1 || busy1) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL rstmid_quiet: got %0d active cycles expected 0", stray);
    else n_pass++;
    run_sweep(NPIX + 50, 200, 0);
    n_checks++;
    if (first_k !== 2 || first_x !== 8'd0 || first_y !== 7'd0)
      $display("FAIL restart_first: got t+%0d (%0d,%0d) expected t+2 (0,0)", first_k, first_x, first_y);
    else n_pass++;
    n_checks++;
    if (n_plot !== 200 || pos_err !== 0 || col_err !== 0)
      $display("FAIL restart_pixels: got %0d plots %0d/%0d errors expected 200 0/0", n_plot, pos_err, col_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_image();
    test_solid_disturbed();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
